// File: rtl/sweep_scheduler_pkg.sv
// Shared grid parameters, sweep FSM states and neighbour-offset helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sweep_scheduler_pkg;

  // Default grid: 640x480 pixels at 4x4 pixels per cell.
  localparam int DEF_X_NUM  = 160;
  localparam int DEF_Y_NUM  = 120;
  localparam int DEF_X_BITS = 8;
  localparam int DEF_Y_BITS = 7;

  // Last neighbour slot of the 3x3 window (slot 4 is the centre cell).
  localparam logic [3:0] K_LAST = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SETTLE,
    WRITE,
    HOLD
  } sweep_state_t;

  // dx = k mod 3 - 1, written as a table so no divider is inferred.
  function automatic logic signed [1:0] nbr_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: nbr_dx = -2'sd1;
      4'd1, 4'd4, 4'd7: nbr_dx = 2'sd0;
      default:          nbr_dx = 2'sd1;
    endcase
  endfunction

  // dy = k div 3 - 1.
  function automatic logic signed [1:0] nbr_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: nbr_dy = -2'sd1;
      4'd3, 4'd4, 4'd5: nbr_dy = 2'sd0;
      default:          nbr_dy = 2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/sweep_scheduler_if.sv
// Control/address bundle between the sweep scheduler and the environment side.
// Latency: n/a (wires only).
// Backpressure: none; pause is a level hold request sampled at cell boundaries.
// Signals: game_tick/run/pause in to the scheduler; view_* lookup address,
// write_* commit address and strobe, busy/sweep_done/overrun/sweep_count status out.
interface sweep_scheduler_if #(
  parameter int X_bits = 8,
  parameter int Y_bits = 7
);
  logic              game_tick;
  logic              run;
  logic              pause;
  logic [X_bits-1:0] view_x;
  logic [Y_bits-1:0] view_y;
  logic              view_valid;
  logic [3:0]        view_idx;
  logic [X_bits-1:0] write_x;
  logic [Y_bits-1:0] write_y;
  logic              write_flag;
  logic              busy;
  logic              sweep_done;
  logic              overrun;
  logic [15:0]       sweep_count;

  modport master (
    input  game_tick, run, pause,
    output view_x, view_y, view_valid, view_idx,
    output write_x, write_y, write_flag,
    output busy, sweep_done, overrun, sweep_count
  );

  modport slave (
    output game_tick, run, pause,
    input  view_x, view_y, view_valid, view_idx,
    input  write_x, write_y, write_flag,
    input  busy, sweep_done, overrun, sweep_count
  );
endinterface

// File: rtl/sweep_scheduler_torus_offset.sv
// Adds a delta of -1/0/+1 to a coordinate with toroidal wrap at limit.
// Latency: combinational.
// Backpressure: none.
// Ports: coord_i, delta_i (signed), limit_i (cell count) -> coord_o.
module torus_offset #(
  parameter int W = 8
) (
  input  logic [W-1:0]       coord_i,
  input  logic signed [1:0]  delta_i,
  input  logic [W-1:0]       limit_i,
  output logic [W-1:0]       coord_o
);
  // Compare-and-select keeps this valid for non-power-of-two limits.
  always_comb begin
    coord_o = coord_i;
    if (delta_i == -2'sd1) begin
      coord_o = (coord_i == '0) ? limit_i - 1'b1 : coord_i - 1'b1;
    end else if (delta_i == 2'sd1) begin
      coord_o = (coord_i == limit_i - 1'b1) ? '0 : coord_i + 1'b1;
    end
  end
endmodule

// File: rtl/sweep_scheduler.sv
// Walks every grid cell per game tick: 9 neighbour reads, a settle cycle, one write strobe.
// Latency: tick to first view_valid 1 cycle; 11 cycles per cell; all outputs registered.
// Backpressure: pause holds at the next cell boundary; run low aborts; ticks while busy set overrun.
// Ports: CLOCK_50, RESET_SIM_N (async, active-low), bus (sweep_scheduler_if.master).
module sweep_scheduler
  import sweep_scheduler_pkg::*;
#(
  parameter int X_NUM  = DEF_X_NUM,
  parameter int Y_NUM  = DEF_Y_NUM,
  parameter int X_bits = DEF_X_BITS,
  parameter int Y_bits = DEF_Y_BITS
) (
  input  logic               CLOCK_50,
  input  logic               RESET_SIM_N,
  sweep_scheduler_if.master  bus
);
  localparam logic [X_bits-1:0] X_LIM = X_bits'(X_NUM);
  localparam logic [Y_bits-1:0] Y_LIM = Y_bits'(Y_NUM);
  localparam logic [X_bits-1:0] X_MAX = X_bits'(X_NUM - 1);
  localparam logic [Y_bits-1:0] Y_MAX = Y_bits'(Y_NUM - 1);

  sweep_state_t      state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [X_bits-1:0] wx_q, wx_d, vx_q, vx_d, nx;
  logic [Y_bits-1:0] wy_q, wy_d, vy_q, vy_d, ny;
  logic [3:0]        vidx_q, vidx_d;
  logic              vvalid_q, vvalid_d;
  logic              wflag_q, wflag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       count_q, count_d;
  logic              cell_last;

  // Neighbour address is built from next-state values so it can be registered
  // and appear in the same cycle as the matching view_idx.
  torus_offset #(.W(X_bits)) u_off_x (
    .coord_i (wx_d),
    .delta_i (nbr_dx(k_d)),
    .limit_i (X_LIM),
    .coord_o (nx)
  );

  torus_offset #(.W(Y_bits)) u_off_y (
    .coord_i (wy_d),
    .delta_i (nbr_dy(k_d)),
    .limit_i (Y_LIM),
    .coord_o (ny)
  );

  assign cell_last = (wx_q == X_MAX) && (wy_q == Y_MAX);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    done_d    = 1'b0;
    count_d   = count_q;
    overrun_d = overrun_q | (bus.game_tick & busy_q);

    case (state_q)
      IDLE: begin
        if (bus.game_tick && bus.run) begin
          state_d = PRIME;
          k_d     = '0;
          wx_d    = '0;
          wy_d    = '0;
        end
      end
      PRIME: begin
        if (k_q == K_LAST) state_d = SETTLE;
        else               k_d = k_q + 4'd1;
      end
      SETTLE: state_d = WRITE;
      WRITE: begin
        if (cell_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end else begin
          if (wx_q == X_MAX) begin
            wx_d = '0;
            wy_d = wy_q + 1'b1;
          end else begin
            wx_d = wx_q + 1'b1;
          end
          k_d     = '0;
          state_d = bus.pause ? HOLD : PRIME;
        end
      end
      HOLD: begin
        if (!bus.pause) begin
          state_d = PRIME;
          k_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving RUN wins over everything: no completion is credited.
    if (state_q != IDLE && !bus.run) begin
      state_d = IDLE;
      done_d  = 1'b0;
      count_d = count_q;
    end

    if (state_d == IDLE) begin
      k_d  = '0;
      wx_d = '0;
      wy_d = '0;
    end

    // View address tracks PRIME, freezes elsewhere, clears when idle.
    vvalid_d = (state_d == PRIME);
    wflag_d  = (state_d == WRITE);
    busy_d   = (state_d != IDLE);
    vidx_d   = vidx_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    if (state_d == PRIME) begin
      vidx_d = k_d;
      vx_d   = nx;
      vy_d   = ny;
    end else if (state_d == IDLE) begin
      vidx_d = '0;
      vx_d   = '0;
      vy_d   = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      state_q   <= IDLE;
      k_q       <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      vidx_q    <= '0;
      vvalid_q  <= 1'b0;
      wflag_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      vidx_q    <= vidx_d;
      vvalid_q  <= vvalid_d;
      wflag_q   <= wflag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign bus.view_x      = vx_q;
  assign bus.view_y      = vy_q;
  assign bus.view_valid  = vvalid_q;
  assign bus.view_idx    = vidx_q;
  assign bus.write_x     = wx_q;
  assign bus.write_y     = wy_q;
  assign bus.write_flag  = wflag_q;
  assign bus.busy        = busy_q;
  assign bus.sweep_done  = done_q;
  assign bus.overrun     = overrun_q;
  assign bus.sweep_count = count_q;

endmodule

// File: doc/sweep_scheduler.md
# sweep_scheduler

Sequences the environment grid update for one game tick. On each tick it walks the write location over every cell in raster order. For each cell it first drives the view location through the 3x3 toroidal neighbourhood so the environment cache captures the surrounding sugar and signal values, then asserts `write_flag` for exactly one cycle. It sits between the game clock divider and the `environment`/`env_cache`/ant array, replacing free-running location counters during RUN.

## Interface

Parameters:
- `X_NUM`, default 160: grid width in cells (640/4).
- `Y_NUM`, default 120: grid height in cells (480/4).
- `X_bits`, default 8: width of x coordinates.
- `Y_bits`, default 7: width of y coordinates.

Ports:
- `CLOCK_50`  in  1  sole clock.
- `RESET_SIM_N`  in  1  reset, asynchronous, active-low.
- `game_tick`  in  1  single-cycle pulse requesting one sweep.
- `run`  in  1  level; high = simulation running (`~SETUP_MODE`).
- `pause`  in  1  level; high = hold at the next cell boundary.
- `view_x`  out  X_bits  lookup x for `environment`.
- `view_y`  out  Y_bits  lookup y.
- `view_valid`  out  1  view address is meaningful this cycle.
- `view_idx`  out  4  neighbour slot 0..8 being read (4 = centre).
- `write_x`  out  X_bits  current cell x.
- `write_y`  out  Y_bits  current cell y.
- `write_flag`  out  1  one-cycle commit strobe for the current cell.
- `busy`  out  1  sweep in progress, including while paused.
- `sweep_done`  out  1  one-cycle pulse after the last cell's write.
- `overrun`  out  1  sticky: a tick arrived while busy.
- `sweep_count`  out  16  completed sweeps, wraps at 65535→0.

## Operation

States: IDLE, PRIME, SETTLE, WRITE, HOLD.

- **IDLE**
  - `game_tick && run` → PRIME. Set `write_x`=0, `write_y`=0, k=0.
  - A tick while `run`=0 is ignored.
- **PRIME**
  - `view_valid`=1 and `view_idx`=k.
  - dx = k mod 3 − 1 and dy = k div 3 − 1.
  - `view_x` = (`write_x`+dx) mod X_NUM and `view_y` = (`write_y`+dy) mod Y_NUM. Coordinates wrap toroidally: x=0, dx=−1 gives X_NUM−1.
  - k increments each cycle. After k=8 → SETTLE.
- **SETTLE**: one cycle with `view_valid`=0. It covers the environment's one-cycle registered lookup latency. → WRITE.
- **WRITE**
  - `write_flag`=1 for this single cycle.
  - If the cell is (X_NUM−1, Y_NUM−1): pulse `sweep_done` next cycle, increment `sweep_count`, → IDLE.
  - Otherwise advance raster order (x+1; at X_NUM−1, x→0 and y+1). Then → HOLD if `pause`, else → PRIME with k=0.
- **HOLD**: all outputs frozen at the new cell, `view_valid`=0. When `pause` falls → PRIME with k=0.
- `game_tick` while `busy`: ignored, and `overrun` set. It clears only on reset.
- `run` falling in any non-IDLE state: synchronous abort to IDLE next cycle.
  - No `write_flag` is issued; `sweep_count` is unchanged.
  - Coordinates reset to 0.

## Timing

- Reset values: state IDLE; all coordinates 0; `view_idx`=0; `view_valid`, `write_flag`, `busy`, `sweep_done`, `overrun` = 0; `sweep_count`=0.
- Cycle costs:
  - 11 cycles per cell: 9 PRIME, 1 SETTLE, 1 WRITE.
  - Full sweep = 11·X_NUM·Y_NUM cycles, which is 211200 at default parameters.
  - The tick-to-first-`view_valid` latency is 1 cycle.
- `busy` goes high the cycle after the accepted tick and falls together with the `sweep_done` pulse.
- All outputs are registered; no combinational input-to-output paths.
- Width rules: wrap is done by compare-and-select, not by a modulo operator. X_NUM and Y_NUM need not be powers of two.

## Structure

- `X_NUM`, `Y_NUM`, `X_bits`, `Y_bits` live in `params.sv`.
- The state enum `sweep_state_t` is added to `params.sv`.
- One sub-module, `torus_offset`. It is combinational and takes (coord, delta ∈ {−1,0,+1}, limit) to produce the wrapped coord. It is instantiated twice, once for x and once for y.
- Top-level integration:
  - `write_flag` and `write_x`/`write_y` replace `simState_controller`'s outputs.
  - `view_*` drives `viewLoc`'s consumers.
  - `view_idx` selects the `env_cache` slot.

## Test plan

Bench parameters: X_NUM=4, Y_NUM=3.

1. **Basic sweep.** Reset, `run`=1, one tick.
   - Expect 12 `write_flag` pulses in raster order (0,0)…(3,2), 11 cycles apart.
   - `sweep_done` is high at cycle 133 after the tick.
   - `sweep_count`=1.
2. **Wrap at origin.** Cell (0,0), k=0: view=(3,2). k=8: view=(1,1). Cell (3,2), k=8: view=(0,0).
3. **Pause.** Assert `pause` during the 3rd cell's PRIME.
   - The WRITE at (2,0) completes, then the block holds at (3,0) with no `write_flag` for 50 cycles.
   - On release, PRIME restarts at k=0 for (3,0).
4. **Overrun.** A second tick 20 cycles after the first: `overrun`=1, the sweep is unaffected, `sweep_count`=1 at the end.
5. **Abort.** `run`→0 at cycle 40.
   - IDLE next cycle, `busy`=0, coordinates (0,0), `sweep_count`=0.
   - A later tick while `run`=0 is ignored.
6. **Reset mid-sweep.** `RESET_SIM_N` low asynchronously mid-PRIME: all outputs reach reset values without a clock edge.
